// File: rtl/line_prefetcher_if.sv
// DDR3 read-port bundle between the line prefetcher (master) and the DDR3 reader (slave).
interface line_prefetcher_if;
    logic [26:0] read_address;
    logic [15:0] read_data_out;
    logic        read_data_valid;

    modport master (output read_address, input read_data_out, input read_data_valid);
    modport slave  (input read_address, output read_data_out, output read_data_valid);
endinterface

// File: rtl/line_prefetcher.sv
// Scanline prefetcher: walks LINE_WORDS DDR3 words into one bank of a double-buffered
// line store while the display side reads the other bank with one-cycle latency.
module line_prefetcher #(
    parameter int LINE_WORDS    = 640,
    parameter int IDX_W         = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_start,
    input  logic [26:0]          line_base,
    line_prefetcher_if.master    rd,
    input  logic [IDX_W-1:0]     pix_idx,
    output logic [15:0]          pix_data,
    output logic                 busy,
    output logic                 line_done,
    output logic                 overrun
);
    localparam int AW   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT_VALID, DONE} state_t;

    state_t            state;
    logic              fill_bank;
    logic [IDX_W-1:0]  word_cnt;
    logic [SC_W-1:0]   settle_cnt;
    logic [26:0]       addr;
    logic              capture;
    logic [15:0]       line_mem [2][LINE_WORDS];

    assign rd.read_address = addr;
    // A new line_start wins over a coincident valid word: the aborted fetch stores nothing more.
    assign capture = (state == WAIT_VALID) && rd.read_data_valid && !line_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fill_bank  <= 1'b0;
            addr       <= '0;
            word_cnt   <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (line_start) begin
                fill_bank  <= ~fill_bank;
                addr       <= line_base;
                word_cnt   <= '0;
                settle_cnt <= '0;
                busy       <= 1'b1;
                state      <= SETTLE;
                if (state == SETTLE || state == WAIT_VALID)
                    overrun <= 1'b1;
            end else begin
                case (state)
                    IDLE: busy <= 1'b0;
                    SETTLE: begin
                        if (settle_cnt == SC_W'(SETTLE_CYCLES - 1))
                            state <= WAIT_VALID;
                        else
                            settle_cnt <= settle_cnt + 1'b1;
                    end
                    WAIT_VALID: begin
                        if (rd.read_data_valid) begin
                            if (word_cnt == IDX_W'(LINE_WORDS - 1)) begin
                                state     <= DONE;
                                busy      <= 1'b0;
                                line_done <= 1'b1;
                            end else begin
                                word_cnt   <= word_cnt + 1'b1;
                                addr       <= addr + 27'd1;
                                settle_cnt <= '0;
                                state      <= SETTLE;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            line_mem[fill_bank][word_cnt[AW-1:0]] <= rd.read_data_out;
    end

    // Display read uses the bank select as it stands before any same-cycle swap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pix_data <= '0;
        else if ({1'b0, pix_idx} < (IDX_W + 1)'(LINE_WORDS))
            pix_data <= line_mem[~fill_bank][pix_idx[AW-1:0]];
        else
            pix_data <= '0;
    end
endmodule
